load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the ALU address output and the data memory port of the RV32I core.
- Turns a decoded load/store (funct3, ALU address, rs2 data, rd) into a word-aligned memory request with byte strobes.
- Handles a valid/grant/rvalid memory handshake with variable latency.
- Holds the core with a stall signal until the access completes.
- Returns sign- or zero-extended load data for register writeback.

Parameters:
TIMEOUT, 16, cycles spent in REQ+WAIT before the access is aborted with err (minimum 2)
CNT_W, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  input  1  core clock, rising edge
rst  input  1  reset: synchronous, active-low (asserted when 0, sampled on rising clk)
req_valid  input  1  load or store present this cycle
req_ready  output  1  LSU can accept a request (state IDLE)
is_store  input  1  1=store, 0=load
funct3  input  3  lb/sb=000, lh/sh=001, lw/sw=010, lbu=100, lhu=101
addr  input  32  effective address from ALU
store_data  input  32  rs2 value
rd  input  5  load destination register
stall  output  1  freeze PC/regfile write
wb_valid  output  1  one-cycle pulse: load data valid
wb_rd  output  5  destination of wb_data
wb_data  output  32  extended load result
err  output  1  one-cycle pulse: timeout or misalign abort
mem_req  output  1  memory request
mem_we  output  1  write enable
mem_addr  output  32  word address ({addr[31:2],2'b00})
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte strobes
mem_gnt  input  1  memory accepted request
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (rst=0 at clk edge) forces IDLE from any state, aborting any in-flight access. All outputs go to 0 while in IDLE with no request, except req_ready=1. No DONE pulse is produced for an aborted access.
- IDLE: req_ready=1. On req_valid=1, latch is_store, funct3, addr, store_data and rd, clear the counter, and go to REQ. funct3 011/110/111 is treated as a word access.
- REQ: mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable from the latch.
  - Store with mem_gnt: go to DONE.
  - Load with mem_gnt and mem_rvalid in the same cycle: capture data, go to DONE.
  - Load with mem_gnt only: go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata and go to DONE.
- Timeout: the counter increments in REQ and WAIT. When the counter equals TIMEOUT-1 with no completion, go to DONE with an abort flag. In DONE an aborted access gives err=1 and wb_valid=0.
- DONE: lasts one cycle, then IDLE.
  - stall=0, req_ready=0: the core advances this edge and the same instruction's req_valid is ignored.
  - Load: wb_valid=1 unless aborted.
- stall = (IDLE & req_valid) | REQ | WAIT. It is combinational from req_valid.
- Store lanes (o = addr[1:0]):
  - byte: wdata={4{d[7:0]}}, wstrb=0001<<o
  - half: wdata={2{d[15:0]}}, wstrb=0011<<{o[1],0}
  - word: wstrb=1111
- Load extract: shift rdata right by 8*o (halfword uses o[1] only). lb/lh sign-extend, lbu/lhu zero-extend.
- Minimum latency, accept to DONE:
  - store with immediate gnt: 2 cycles.
  - load with gnt+rvalid in the same cycle: 2 cycles.
  - load with rvalid the cycle after gnt: 3 cycles.
- mem_rvalid outside WAIT/REQ-load is ignored.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, skips REQ. It goes IDLE to DONE with err=1, mem_req is never raised, and wb_valid=0.
- Undefined: low address bits are ignored for misaligned accesses. A half uses lane o[1], a word uses the full word, and err comes only from timeout.

Decomposition:
Shared package lsu_pkg holds:
- the state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
- funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU

Sub-module lsu_align (combinational) does store lane replication and strobe generation plus load extraction/extension. The top keeps the FSM, latch and timeout counter.

Test Plan:
1. sw addr=0x100, data=0xDEADBEEF, gnt immediate -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, stall high 2 cycles, no wb_valid.
2. sb addr=0x103, data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
3. lb addr=0x102, rdata=0x00800000, rvalid the cycle after gnt -> wb_data=0xFFFFFF80, wb_valid one cycle, wb_rd=latched rd. Same with lbu -> 0x00000080.
4. lh addr=0x0, gnt never asserted, TIMEOUT=16 -> err pulse after 16 REQ cycles, wb_valid=0, return to IDLE.
5. rst=0 while in WAIT, then rvalid -> IDLE, no wb_valid/err, req_ready=1 next cycle.
6. With LSU_MISALIGN_TRAP_EN: lw addr=0x101 -> mem_req stays 0, err=1 in DONE. Without it: mem_addr=0x100, wstrb=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 constants and access-size helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Encodings 011/110/111 fall through to a word access.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SzByte;
            F3_H, F3_HU: sz = SzHalf;
            F3_W:        sz = SzWord;
            default:     sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        lsu_size_e sz;
        sz = lsu_size(f3);
        return ((sz == SzHalf) && off[0]) || ((sz == SzWord) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store replication/strobes and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    lsu_size_e   size;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign size   = lsu_size(funct3);
    assign byte_v = rdata[{offset, 3'b000} +: 8];
    // Halfwords only ever use the upper/lower lane; offset[0] is ignored.
    assign half_v = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = rdata;
        unique case (size)
            SzByte: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << offset;
                load_data = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SzHalf: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << {offset[1], 1'b0};
                load_data = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: latches one access, runs the gnt/rvalid handshake with a timeout.
// Define LSU_MISALIGN_TRAP_EN to abort misaligned half/word accesses without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e       state_q;
    logic             store_q;
    logic             abort_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      sdata_q;
    logic [31:0]      rdata_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic        timeout;
    logic        trap;
    logic [31:0] al_wdata;
    logic [3:0]  al_strb;
    logic [31:0] al_load;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = lsu_misaligned(funct3, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            store_q <= 1'b0;
            abort_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        store_q <= is_store;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        sdata_q <= store_data;
                        rd_q    <= rd;
                        cnt_q   <= '0;
                        abort_q <= trap;
                        state_q <= trap ? StDone : StReq;
                    end
                end
                StReq: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (mem_gnt && (store_q || mem_rvalid)) begin
                        rdata_q <= mem_rdata;
                        state_q <= StDone;
                    end else if (timeout) begin
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (mem_gnt) begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        state_q <= StDone;
                    end else if (timeout) begin
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (rdata_q),
        .wdata      (al_wdata),
        .wstrb      (al_strb),
        .load_data  (al_load)
    );

    assign req_ready = (state_q == StIdle);
    assign stall     = ((state_q == StIdle) && req_valid) || (state_q == StReq) ||
                       (state_q == StWait);

    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'b0;
    assign mem_wdata = mem_req ? al_wdata : 32'b0;
    assign mem_wstrb = mem_req ? al_strb : 4'b0;

    assign wb_valid  = (state_q == StDone) && !store_q && !abort_q;
    assign wb_rd     = wb_valid ? rd_q : 5'b0;
    assign wb_data   = wb_valid ? al_load : 32'b0;
    assign err       = (state_q == StDone) && abort_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus directed literal vectors.
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT (TO),
        .CNT_W   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int m_size(input bit [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic int m_base(input bit [2:0] f3, input bit [31:0] a);
        int n;
        n = m_size(f3);
        if (n == 4) return 0;
        if (n == 2) return int'(a & 32'h2);
        return int'(a & 32'h3);
    endfunction

    function automatic bit [3:0] m_strb(input bit [2:0] f3, input bit [31:0] a);
        int lanes;
        lanes = (1 << m_size(f3)) - 1;
        return 4'(lanes << m_base(f3, a));
    endfunction

    function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit [31:0] d);
        int n;
        n = m_size(f3);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a,
                                         input bit [31:0] rdat);
        bit [31:0] v;
        bit [31:0] mask;
        if (m_size(f3) == 4) return rdat;
        mask = (m_size(f3) == 1) ? 32'hFF : 32'hFFFF;
        v = (rdat >> (8 * m_base(f3, a))) & mask;
        if (!f3[2] && ((v & ((mask + 1) >> 1)) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_trap(input bit [2:0] f3, input bit [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % m_size(f3)) != 0;
`else
        return (f3 != 3'b111) && (a === 32'hx);
`endif
    endfunction

    // Expectation for the transaction in flight; k counts cycles from the accept cycle (k=0).
    bit        active;
    bit        free;
    int        cur_k;
    string     e_name;
    bit        e_store;
    bit [2:0]  e_f3;
    bit [31:0] e_addr;
    bit [31:0] e_data;
    bit [4:0]  e_rd;
    bit [31:0] e_rdata;
    bit        e_trap;
    bit        e_abort;
    int        e_done;
    int        e_req_end;

    task automatic plan(input bit st, input int gnt_at, input int rv_at);
        bit gok;
        int c;
        if (e_trap) begin
            e_done = 1; e_abort = 1'b1; e_req_end = 0;
        end else begin
            gok = (gnt_at >= 1) && (gnt_at <= TO);
            e_req_end = gok ? gnt_at : TO;
            if (st) c = gok ? gnt_at : 1000;
            else    c = (gok && rv_at >= gnt_at) ? rv_at : 1000;
            if (c <= TO) begin
                e_done = c + 1; e_abort = 1'b0;
            end else begin
                e_done = TO + 1; e_abort = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && !free) begin
            if (active) begin
                bit exp_req;
                bit exp_wb;
                exp_req = (cur_k >= 1) && (cur_k <= e_req_end);
                exp_wb  = (cur_k == e_done) && !e_store && !e_abort;
                check({e_name, " stall"}, stall, (cur_k < e_done));
                check({e_name, " req_ready"}, req_ready, (cur_k == 0));
                check({e_name, " mem_req"}, mem_req, exp_req);
                if (exp_req) begin
                    check({e_name, " mem_addr"}, mem_addr, e_addr & 32'hFFFF_FFFC);
                    check({e_name, " mem_we"}, mem_we, e_store);
                    check({e_name, " mem_wstrb"}, mem_wstrb, m_strb(e_f3, e_addr));
                    check({e_name, " mem_wdata"}, mem_wdata, m_wdata(e_f3, e_data));
                end
                check({e_name, " wb_valid"}, wb_valid, exp_wb);
                check({e_name, " err"}, err, (cur_k == e_done) && e_abort);
                if (exp_wb) begin
                    check({e_name, " wb_data"}, wb_data, m_load(e_f3, e_addr, e_rdata));
                    check({e_name, " wb_rd"}, wb_rd, e_rd);
                end
            end else begin
                check("idle req_ready", req_ready, 1);
                check("idle stall", stall, req_valid);
                check("idle mem_req", mem_req, 0);
                check("idle wb_valid", wb_valid, 0);
                check("idle err", err, 0);
            end
        end
    end

    task automatic run_txn(input string name, input bit st, input bit [2:0] f3,
                           input bit [31:0] a, input bit [31:0] d, input bit [4:0] r,
                           input int gnt_at, input int rv_at, input bit [31:0] rdat,
                           input int lit_done, input bit [3:0] lit_strb,
                           input bit [31:0] lit_wdata, input bit [31:0] lit_wb,
                           input bit lit_err);
        bit        seen;
        int        done_k;
        bit [3:0]  cap_strb;
        bit [31:0] cap_wdata;
        bit [31:0] cap_wb;
        bit        cap_err;
        seen = 1'b0; done_k = -1; cap_strb = '0; cap_wdata = '0; cap_wb = '0; cap_err = 1'b0;
        e_name = name; e_store = st; e_f3 = f3; e_addr = a; e_data = d; e_rd = r;
        e_rdata = rdat; e_trap = m_trap(f3, a);
        plan(st, gnt_at, rv_at);
        is_store = st; funct3 = f3; addr = a; store_data = d; rd = r; mem_rdata = rdat;
        active = 1'b1;
        for (int j = 0; j < 40 && !seen; j++) begin
            cur_k = j;
            req_valid  = 1'b1;
            mem_gnt    = (j == gnt_at);
            mem_rvalid = (j == rv_at);
            @(negedge clk);
            if (mem_req) begin
                cap_strb  = mem_wstrb;
                cap_wdata = mem_wdata;
            end
            if (j > 0 && !stall && !req_ready) begin
                seen = 1'b1; done_k = j; cap_wb = wb_data; cap_err = err;
            end
            @(posedge clk);
            #1;
        end
        active = 1'b0; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check({name, " done seen"}, seen, 1);
        check({name, " latency"}, done_k, lit_done);
        check({name, " lit wstrb"}, cap_strb, lit_strb);
        check({name, " lit wdata"}, cap_wdata, lit_wdata);
        check({name, " lit wb_data"}, cap_wb, lit_wb);
        check({name, " lit err"}, cap_err, lit_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        free = 1'b1; active = 1'b0; cur_k = 0;
        rst = 1'b0; req_valid = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
        store_data = '0; rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset stall", stall, 0);
        check("reset mem_req", mem_req, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset err", err, 0);
        check("reset mem_wstrb", mem_wstrb, 0);
        rst = 1'b1; free = 1'b0;
        @(posedge clk);
        #1;

        //      name    st   f3      addr          data          rd  gnt rv  rdata
        //      done strb   wdata         wb            err
        run_txn("sw",   1, 3'b010, 32'h100, 32'hDEADBEEF, 0,  1, -1, 32'h0,
                2, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        run_txn("sb",   1, 3'b000, 32'h103, 32'h000000A5, 0,  1, -1, 32'h0,
                2, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        run_txn("lb",   0, 3'b000, 32'h102, 32'h0, 5,  1,  2, 32'h00800000,
                3, 4'h4, 32'h0, 32'hFFFFFF80, 0);
        run_txn("lbu",  0, 3'b100, 32'h102, 32'h0, 6,  1,  2, 32'h00800000,
                3, 4'h4, 32'h0, 32'h00000080, 0);

        // Reset while waiting for read data: access is dropped without any pulse.
        free = 1'b1;
        is_store = 1'b0; funct3 = 3'b000; addr = 32'h102; rd = 9; mem_rdata = 32'h00800000;
        req_valid = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; req_valid = 1'b0;
        check("rstwait mem_req", mem_req, 0);
        check("rstwait stall", stall, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; mem_rvalid = 1'b1;
        check("rstwait req_ready", req_ready, 1);
        check("rstwait stall idle", stall, 0);
        check("rstwait wb_valid", wb_valid, 0);
        check("rstwait err", err, 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("rstwait late wb_valid", wb_valid, 0);
        check("rstwait late err", err, 0);
        check("rstwait late req_ready", req_ready, 1);
        @(posedge clk); #1;
        free = 1'b0;

        run_txn("lw",   0, 3'b010, 32'h200, 32'h0, 7,  1,  1, 32'h12345678,
                2, 4'hF, 32'h0, 32'h12345678, 0);
        run_txn("lh_to", 0, 3'b001, 32'h0, 32'h0, 8, -1, -1, 32'h0,
                17, 4'h3, 32'h0, 32'h0, 1);
        run_txn("sh",   1, 3'b001, 32'h106, 32'h0000BEEF, 0, 3, -1, 32'h0,
                4, 4'hC, 32'hBEEFBEEF, 32'h0, 0);
        run_txn("lhu",  0, 3'b101, 32'h2, 32'h0, 10, 1,  4, 32'h80010000,
                5, 4'hC, 32'h0, 32'h00008001, 0);
        run_txn("lh",   0, 3'b001, 32'h2, 32'h0, 11, 2,  2, 32'h80010000,
                3, 4'hC, 32'h0, 32'hFFFF8001, 0);
        run_txn("lw_to", 0, 3'b010, 32'h400, 32'h0, 3, 1, -1, 32'h0,
                17, 4'hF, 32'h0, 32'h0, 1);
        run_txn("lb_pos", 0, 3'b000, 32'h101, 32'h0, 12, 1, 1, 32'h00007F00,
                2, 4'h2, 32'h0, 32'h0000007F, 0);
        run_txn("f3_111", 0, 3'b111, 32'h300, 32'h0, 13, 1, 1, 32'hCAFEF00D,
                2, 4'hF, 32'h0, 32'hCAFEF00D, 0);
        run_txn("sw_lategnt", 1, 3'b010, 32'h10, 32'h01020304, 0, 16, -1, 32'h0,
                17, 4'hF, 32'h01020304, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        run_txn("lw_mis", 0, 3'b010, 32'h101, 32'h0, 14, 1, 1, 32'h11223344,
                1, 4'h0, 32'h0, 32'h0, 1);
`else
        run_txn("lw_mis", 0, 3'b010, 32'h101, 32'h0, 14, 1, 1, 32'h11223344,
                2, 4'hF, 32'h0, 32'h11223344, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
